wbu: RTL and testbench

// - Write-back/commit stage of the multi-cycle RV32 core; sits directly downstream of lsu.
// - Latches one decoded/executed instruction and waits for lsu's wbu_valid.
// - Selects the write-back data, writes the integrated register file and updates the architectural PC.
// - Pulses commit so ifu can fetch the next instruction; also keeps the retired-instruction count and a sticky halt.

---
 rtl/wbu_if.sv | 40 ++++
 rtl/wbu.sv | 140 ++++++++++++++
 tb/tb_wbu.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/wbu_if.sv
// Bus between exu/lsu/ifu and the write-back stage: instruction capture, lsu data,
// register-file read ports and the commit/architectural-state outputs.
interface wbu_if #(
  parameter int XLEN = 32
);
  logic            inst_valid;
  logic            inst_ready;
  logic [4:0]      rd;
  logic            reg_wen;
  logic [1:0]      wb_sel;
  logic [XLEN-1:0] exu_result;
  logic [XLEN-1:0] csr_rdata;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] dnpc;
  logic            halt;
  logic            lsu_valid;
  logic [XLEN-1:0] memory_read_wd;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            commit_valid;
  logic [XLEN-1:0] pc_out;
  logic [63:0]     instret;
  logic            halted;

  // Handshake: an instruction transfers on a cycle where inst_valid & inst_ready are both 1;
  // inst_valid seen while inst_ready is 0 is dropped, not queued.
  modport slave (
    input  inst_valid, rd, reg_wen, wb_sel, exu_result, csr_rdata, pc, dnpc, halt,
           lsu_valid, memory_read_wd, rs1, rs2,
    output inst_ready, rs1_data, rs2_data, commit_valid, pc_out, instret, halted
  );

  modport master (
    output inst_valid, rd, reg_wen, wb_sel, exu_result, csr_rdata, pc, dnpc, halt,
           lsu_valid, memory_read_wd, rs1, rs2,
    input  inst_ready, rs1_data, rs2_data, commit_valid, pc_out, instret, halted
  );
endinterface

// File: rtl/wbu.sv
// Write-back/commit stage: captures one instruction, waits for lsu data, writes the
// register file, advances the architectural PC and counts retired instructions.
module wbu #(
  parameter int              XLEN     = 32,
  parameter int              NREG     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic       clk,
  input  logic       rst,
  wbu_if.slave       bus,
  output logic [1:0] dbg_state_o
);
  localparam int IW = $clog2(NREG);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_COMMIT = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            capture;
  logic            latch_wdata;
  logic            do_commit;

  logic [4:0]      rd_q;
  logic            reg_wen_q;
  logic [1:0]      wb_sel_q;
  logic [XLEN-1:0] exu_result_q;
  logic [XLEN-1:0] csr_rdata_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] dnpc_q;
  logic            halt_q;
  logic [XLEN-1:0] wdata_q, wdata_d;

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] pc_out_q;
  logic [63:0]     instret_q;
  logic            halted_q;
  logic            rd_writable;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    capture     = 1'b0;
    latch_wdata = 1'b0;
    do_commit   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.inst_valid && !halted_q) begin
          capture = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.lsu_valid) begin
          latch_wdata = 1'b1;
          state_d     = S_COMMIT;
        end
      end
      S_COMMIT: begin
        do_commit = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // memory_read_wd is only guaranteed valid in the cycle lsu_valid is seen, so wdata is frozen then.
  always_comb begin
    wdata_d = wdata_q;
    if (latch_wdata) begin
      case (wb_sel_q)
        2'd0:    wdata_d = exu_result_q;
        2'd1:    wdata_d = bus.memory_read_wd;
        2'd2:    wdata_d = pc_q + XLEN'(4);
        default: wdata_d = csr_rdata_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q         <= '0;
      reg_wen_q    <= 1'b0;
      wb_sel_q     <= '0;
      exu_result_q <= '0;
      csr_rdata_q  <= '0;
      pc_q         <= '0;
      dnpc_q       <= '0;
      halt_q       <= 1'b0;
      wdata_q      <= '0;
    end else begin
      if (capture) begin
        rd_q         <= bus.rd;
        reg_wen_q    <= bus.reg_wen;
        wb_sel_q     <= bus.wb_sel;
        exu_result_q <= bus.exu_result;
        csr_rdata_q  <= bus.csr_rdata;
        pc_q         <= bus.pc;
        dnpc_q       <= bus.dnpc;
        halt_q       <= bus.halt;
      end
      wdata_q <= wdata_d;
    end
  end

  assign rd_writable = reg_wen_q && (rd_q != 5'd0) && ({1'b0, rd_q} < 6'(NREG));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      pc_out_q  <= RESET_PC;
      instret_q <= '0;
      halted_q  <= 1'b0;
    end else if (do_commit) begin
      if (rd_writable) regs_q[rd_q[IW-1:0]] <= wdata_q;
      pc_out_q  <= dnpc_q;
      instret_q <= instret_q + 64'd1;
      halted_q  <= halted_q | halt_q;
    end
  end

  // Reads are not bypassed: a write in COMMIT becomes visible the following cycle.
  assign bus.rs1_data = (bus.rs1 != 5'd0 && {1'b0, bus.rs1} < 6'(NREG))
                        ? regs_q[bus.rs1[IW-1:0]] : '0;
  assign bus.rs2_data = (bus.rs2 != 5'd0 && {1'b0, bus.rs2} < 6'(NREG))
                        ? regs_q[bus.rs2[IW-1:0]] : '0;

  assign bus.inst_ready   = (state_q == S_IDLE);
  assign bus.commit_valid = do_commit;
  assign bus.pc_out       = pc_out_q;
  assign bus.instret      = instret_q;
  assign bus.halted       = halted_q;
  assign dbg_state_o      = state_q;
endmodule

// File: tb/tb_wbu.sv
// Self-checking bench for wbu: directed cases from the block description plus a short
// random run, with a commit-time scoreboard of expected next PCs.
module tb_wbu;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;

  wbu_if #(.XLEN(32)) bus ();

  wbu #(.XLEN(32), .NREG(32), .RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard / model ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_rf [32];
  logic [63:0] exp_ret;
  logic        halted_m;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Every commit pulse must match a previously accepted instruction; pc_out then equals its dnpc.
  always @(posedge clk) begin
    logic [31:0] exp_pc;
    if (!rst && bus.commit_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_commit", 64'd1, 64'd0);
      end else begin
        exp_pc = exp_q.pop_front();
        #1;
        check("pc_out", {32'd0, bus.pc_out}, {32'd0, exp_pc});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst              = 1'b1;
    bus.inst_valid   = 1'b0;
    bus.lsu_valid    = 1'b0;
    bus.rd           = '0;
    bus.reg_wen      = 1'b0;
    bus.wb_sel       = '0;
    bus.exu_result   = '0;
    bus.csr_rdata    = '0;
    bus.pc           = '0;
    bus.dnpc         = '0;
    bus.halt         = 1'b0;
    bus.memory_read_wd = '0;
    bus.rs1          = '0;
    bus.rs2          = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 32; i++) model_rf[i] = '0;
    exp_ret  = '0;
    halted_m = 1'b0;
  endtask

  task automatic accept(input logic [4:0] rd, input logic wen, input logic [1:0] sel,
                        input logic [31:0] exu, input logic [31:0] csr,
                        input logic [31:0] pc, input logic [31:0] dnpc, input logic halt);
    @(negedge clk);
    bus.rd         = rd;
    bus.reg_wen    = wen;
    bus.wb_sel     = sel;
    bus.exu_result = exu;
    bus.csr_rdata  = csr;
    bus.pc         = pc;
    bus.dnpc       = dnpc;
    bus.halt       = halt;
    bus.inst_valid = 1'b1;
    check("inst_ready_idle", {63'd0, bus.inst_ready}, 64'd1);
    if (!halted_m) exp_q.push_back(dnpc);
    @(posedge clk);
    #1 bus.inst_valid = 1'b0;
  endtask

  // Runs one instruction end to end; lsu_valid is held low for 'stall' WAIT cycles.
  task automatic run_inst(input logic [4:0] rd, input logic wen, input logic [1:0] sel,
                          input logic [31:0] exu, input logic [31:0] csr,
                          input logic [31:0] pc, input logic [31:0] dnpc, input logic halt,
                          input logic [31:0] mem, input int stall, input logic stray);
    int          lat;
    logic [31:0] wdata;
    accept(rd, wen, sel, exu, csr, pc, dnpc, halt);
    lat = 1;
    bus.memory_read_wd = mem;
    bus.lsu_valid      = (lat > stall);
    bus.inst_valid     = stray;
    while (!bus.commit_valid && lat < 40) begin
      check("inst_ready_wait", {63'd0, bus.inst_ready}, 64'd0);
      @(posedge clk);
      #1;
      lat++;
      bus.lsu_valid = (lat > stall);
    end
    bus.inst_valid = 1'b0;
    check("commit_latency", 64'(lat), 64'(stall + 2));
    // Commit cycle: destination still shows its old value.
    bus.rs1 = rd;
    bus.rs2 = 5'd0;
    #1;
    check("rd_old", {32'd0, bus.rs1_data}, {32'd0, model_rf[rd]});
    check("x0_rs2", {32'd0, bus.rs2_data}, 64'd0);
    case (sel)
      2'd0:    wdata = exu;
      2'd1:    wdata = mem;
      2'd2:    wdata = pc + 32'd4;
      default: wdata = csr;
    endcase
    if (wen && rd != 5'd0) model_rf[rd] = wdata;
    exp_ret++;
    if (halt) halted_m = 1'b1;
    @(posedge clk);
    #2;
    check("rd_new", {32'd0, bus.rs1_data}, {32'd0, model_rf[rd]});
    check("instret", bus.instret, exp_ret);
    check("halted", {63'd0, bus.halted}, {63'd0, halted_m});
    check("commit_one_cycle", {63'd0, bus.commit_valid}, 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    do_reset();

    // Reset state
    for (int i = 0; i < 32; i++) begin
      bus.rs1 = 5'(i);
      #1 check("reset_reg", {32'd0, bus.rs1_data}, 64'd0);
    end
    check("reset_pc", {32'd0, bus.pc_out}, {32'd0, RESET_PC});
    check("reset_instret", bus.instret, 64'd0);
    check("reset_ready", {63'd0, bus.inst_ready}, 64'd1);
    check("reset_halted", {63'd0, bus.halted}, 64'd0);
    check("reset_state", {62'd0, dbg_state}, 64'd0);

    // ALU op, minimum latency
    run_inst(5'd5, 1'b1, 2'd0, 32'h1234, 32'h0, 32'h8000_0000, 32'h8000_0004, 1'b0,
             32'h0, 0, 1'b0);
    // Load with 3 stall cycles and stray inst_valid during the stall
    run_inst(5'd7, 1'b1, 2'd1, 32'h1000, 32'h0, 32'h8000_0004, 32'h8000_0008, 1'b0,
             32'hFFFF_FF80, 3, 1'b1);
    // Write to x0 is dropped
    run_inst(5'd0, 1'b1, 2'd0, 32'hDEAD, 32'h0, 32'h8000_0008, 32'h8000_000C, 1'b0,
             32'h0, 0, 1'b0);
    // jal link value wraps
    run_inst(5'd9, 1'b1, 2'd2, 32'h0, 32'h0, 32'hFFFF_FFFC, 32'h8000_0100, 1'b0,
             32'h0, 1, 1'b0);
    // CSR read write-back
    run_inst(5'd11, 1'b1, 2'd3, 32'h0, 32'hCAFE_F00D, 32'h8000_0100, 32'h8000_0104, 1'b0,
             32'h0, 0, 1'b0);
    // reg_wen=0 leaves destination untouched
    run_inst(5'd5, 1'b0, 2'd0, 32'h5555_5555, 32'h0, 32'h8000_0104, 32'h8000_0108, 1'b0,
             32'h0, 0, 1'b0);

    // Random mix
    for (int i = 0; i < 10; i++) begin
      logic [31:0] rpc;
      rpc = $urandom & 32'hFFFF_FFFC;
      run_inst(5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
               $urandom, $urandom, rpc, rpc + 32'd4, 1'b0, $urandom, $urandom_range(0, 2), 1'b0);
    end

    // Verify whole register file against the model
    for (int i = 0; i < 32; i++) begin
      bus.rs2 = 5'(i);
      #1 check("rf_sweep", {32'd0, bus.rs2_data}, {32'd0, model_rf[i]});
    end

    // Halt, then further instructions are ignored
    run_inst(5'd0, 1'b0, 2'd0, 32'h0, 32'h0, 32'h8000_0200, 32'h8000_0204, 1'b1,
             32'h0, 0, 1'b0);
    accept(5'd3, 1'b1, 2'd0, 32'h77, 32'h0, 32'h8000_0204, 32'h8000_0208, 1'b0);
    bus.lsu_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("halted_no_commit", {63'd0, bus.commit_valid}, 64'd0);
      check("halted_ready", {63'd0, bus.inst_ready}, 64'd1);
      check("halted_state", {62'd0, dbg_state}, 64'd0);
      @(posedge clk);
      #1;
    end
    check("halted_instret", bus.instret, exp_ret);
    check("halted_pc", {32'd0, bus.pc_out}, 64'h8000_0204);

    // Reset while waiting for lsu aborts the instruction
    do_reset();
    accept(5'd3, 1'b1, 2'd0, 32'h55, 32'h0, 32'h8000_0000, 32'h0000_0100, 1'b0);
    check("abort_state_wait", {62'd0, dbg_state}, 64'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    bus.rs1 = 5'd3;
    #1;
    check("abort_no_write", {32'd0, bus.rs1_data}, 64'd0);
    check("abort_pc", {32'd0, bus.pc_out}, {32'd0, RESET_PC});
    check("abort_instret", bus.instret, 64'd0);
    check("abort_state", {62'd0, dbg_state}, 64'd0);
    repeat (3) @(posedge clk);
    #1 check("abort_no_commit_left", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time limit so the bench always ends on its own.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
